// File: rtl/rv_hazard_ctrl.sv
// Hazard controller: destination scoreboard, bypass selects, load-use stall and flush sequencing.
// Optional build macro RV_BP_WR_BACK_EN enables the wr_back bypass (S_WR match) and the S_WB slot.
package rv_hazard_ctrl_pkg;
    typedef struct packed {
        logic alu2;
        logic memory;
        logic write;
        logic wr_back;
    } ctrl_rs_bp_t;
endpackage

module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic [4:0]  i_dec_rd,
    input  logic        i_dec_reg_write,
    input  logic        i_dec_load,
    input  logic        i_flush_req,
    input  logic        i_stall_ext,
    output ctrl_rs_bp_t o_rs1_bp,
    output ctrl_rs_bp_t o_rs2_bp,
    output logic        o_stall,
    output logic        o_flush_dec,
    output logic        o_flush_alu1
);

`ifdef RV_BP_WR_BACK_EN
    localparam int unsigned NSLOT  = 5;
    localparam int unsigned NMATCH = 4;
`else
    // Without wr_back forwarding nothing ever reads S_WR/S_WB, so the chain stops at S_MEM.
    localparam int unsigned NSLOT  = 3;
    localparam int unsigned NMATCH = 3;
`endif

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_e;

    slot_t       sb_q [NSLOT];
    slot_t       sb_d [NSLOT];
    slot_t       entry;
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    ctrl_rs_bp_t rs1_bp_q, rs1_bp_d, rs2_bp_q, rs2_bp_d;
    logic [3:0]  m1, m2;
    logic        flush_go, lu_hazard;

    // Bit i of m = match against slot i; the youngest producer (lowest index) wins.
    function automatic ctrl_rs_bp_t pick(input logic [3:0] m);
        pick = '0;
        if (m[0])      pick.alu2    = 1'b1;
        else if (m[1]) pick.memory  = 1'b1;
        else if (m[2]) pick.write   = 1'b1;
        else if (m[3]) pick.wr_back = 1'b1;
    endfunction

    always_comb begin
        entry.valid = i_dec_valid && i_dec_reg_write && (i_dec_rd != '0);
        entry.rd    = i_dec_rd;
        entry.load  = i_dec_load;

        m1 = '0;
        m2 = '0;
        for (int unsigned i = 0; i < NMATCH; i++) begin
            m1[i] = sb_q[i].valid && (sb_q[i].rd == i_dec_rs1) && (i_dec_rs1 != '0);
            m2[i] = sb_q[i].valid && (sb_q[i].rd == i_dec_rs2) && (i_dec_rs2 != '0);
        end

        flush_go  = i_flush_req || (state_q == FLUSH);
        lu_hazard = (state_q == RUN) && !i_flush_req && !i_stall_ext && i_dec_valid
                    && sb_q[0].load && (m1[0] || m2[0]);

        for (int unsigned i = 0; i < NSLOT; i++) sb_d[i] = sb_q[i];
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs1_bp_d = rs1_bp_q;
        rs2_bp_d = rs2_bp_q;

        if (i_flush_req) begin
            state_d = FLUSH;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
        end else if (state_q == FLUSH) begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - 3'd1;
        end else if (!i_stall_ext) begin
            state_d = lu_hazard ? LU_STALL : RUN;
        end

        if (!i_stall_ext) begin
            for (int unsigned i = NSLOT - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
            sb_d[0] = (flush_go || lu_hazard) ? '0 : entry;
            rs1_bp_d = (flush_go || lu_hazard || !i_dec_valid) ? '0 : pick(m1);
            rs2_bp_d = (flush_go || lu_hazard || !i_dec_valid) ? '0 : pick(m2);
        end else if (flush_go) begin
            // Frozen pipeline still drops the wrong-path alu1 entry and its bypass.
            sb_d[0]  = '0;
            rs1_bp_d = '0;
            rs2_bp_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) sb_q[i] <= '0;
            state_q  <= RUN;
            cnt_q    <= '0;
            rs1_bp_q <= '0;
            rs2_bp_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) sb_q[i] <= sb_d[i];
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs1_bp_q <= rs1_bp_d;
            rs2_bp_q <= rs2_bp_d;
        end
    end

    assign o_rs1_bp     = rs1_bp_q;
    assign o_rs2_bp     = rs2_bp_q;
    assign o_stall      = i_reset_n && (i_stall_ext || lu_hazard);
    assign o_flush_dec  = i_reset_n && (state_q == FLUSH);
    assign o_flush_alu1 = i_reset_n && ((state_q == FLUSH) || lu_hazard);

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: directed test-plan steps plus random traffic against an
// in-flight instruction list model.
module tb_rv_hazard_ctrl;
    import rv_hazard_ctrl_pkg::*;

    localparam int unsigned FC = 2;
`ifdef RV_BP_WR_BACK_EN
    localparam int NM = 4;
`else
    localparam int NM = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n, dv, wr, ld, req, ext;
    logic [4:0]  rs1, rs2, rd;
    ctrl_rs_bp_t bp1, bp2;
    logic        stall, fd, fa;

    always #5 clk = ~clk;

    rv_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_dec_valid(dv),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_rd(rd),
        .i_dec_reg_write(wr), .i_dec_load(ld),
        .i_flush_req(req), .i_stall_ext(ext),
        .o_rs1_bp(bp1), .o_rs2_bp(bp2), .o_stall(stall),
        .o_flush_dec(fd), .o_flush_alu1(fa)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: instructions in flight by age (0 = in alu1), plus remaining flush cycles.
    logic       p_v  [5];
    logic [4:0] p_rd [5];
    logic       p_ld [5];
    logic [3:0] m_bp1, m_bp2;
    int         m_left;
    bit         m_known = 0;
    logic       o_st, o_fd, o_fa;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] youngest(input logic [4:0] rs);
        logic [3:0] r = '0;
        if (rs != 5'd0)
            for (int d = 0; d < NM; d++)
                if (r == 4'd0 && p_v[d] && p_rd[d] == rs) r = 4'b1000 >> d;
        return r;
    endfunction

    task automatic step();
        bit         in_fl, haz, fl_any;
        logic [3:0] n1, n2;
        @(negedge clk);
        #1;
        o_st = stall; o_fd = fd; o_fa = fa;
        in_fl = (m_left > 0);
        haz = !in_fl && !req && !ext && dv && p_v[0] && p_ld[0] &&
              ((rs1 != 0 && p_rd[0] == rs1) || (rs2 != 0 && p_rd[0] == rs2));
        if (m_known) begin
            chk("rs1_bp", bp1, m_bp1);
            chk("rs2_bp", bp2, m_bp2);
        end
        if (!rst_n) begin
            chk("stall_rst", o_st, 4'd0);
            chk("fdec_rst", o_fd, 4'd0);
            chk("falu1_rst", o_fa, 4'd0);
            for (int i = 0; i < 5; i++) begin p_v[i] = 0; p_rd[i] = '0; p_ld[i] = 0; end
            m_bp1 = '0; m_bp2 = '0; m_left = 0; m_known = 1;
        end else begin
            chk("stall", o_st, 4'(ext || haz));
            chk("flush_dec", o_fd, 4'(in_fl));
            chk("flush_alu1", o_fa, 4'(in_fl || haz));
            fl_any = req || in_fl;
            n1 = youngest(rs1);
            n2 = youngest(rs2);
            if (req) m_left = FC;
            else if (m_left > 0) m_left--;
            if (!ext) begin
                for (int i = 4; i > 0; i--) begin
                    p_v[i] = p_v[i-1]; p_rd[i] = p_rd[i-1]; p_ld[i] = p_ld[i-1];
                end
                p_v[0]  = !(fl_any || haz) && dv && wr && rd != 0;
                p_rd[0] = rd;
                p_ld[0] = ld;
                m_bp1 = (fl_any || haz || !dv) ? 4'd0 : n1;
                m_bp2 = (fl_any || haz || !dv) ? 4'd0 : n2;
            end else if (fl_any) begin
                p_v[0] = 0; m_bp1 = '0; m_bp2 = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        dv = 0; rs1 = '0; rs2 = '0; rd = '0; wr = 0; ld = 0; req = 0; ext = 0;
    endtask

    task automatic ins(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic l);
        nop();
        dv = 1; rs1 = a; rs2 = b; rd = d; wr = w; ld = l;
        step();
    endtask

    initial begin
        int         cnt;
        logic [3:0] held;
        nop();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
        chk("reset_bp1", bp1, 4'd0);
        chk("reset_bp2", bp2, 4'd0);
        chk("reset_stall", stall, 4'd0);
        chk("reset_fdec", fd, 4'd0);

        // Back-to-back ALU dependency
        ins(5'd0, 5'd0, 5'd5, 1, 0);
        ins(5'd5, 5'd0, 5'd0, 0, 0);
        chk("b2b_stall", o_st, 4'd0);
        chk("b2b_bp1", bp1, 4'b1000);
        chk("b2b_bp2", bp2, 4'd0);

        // Distance 3 and 4
        ins(5'd0, 5'd0, 5'd7, 1, 0);
        nop(); step(); step();
        ins(5'd0, 5'd7, 5'd0, 0, 0);
        chk("dist3_bp2", bp2, 4'b0010);
        ins(5'd0, 5'd0, 5'd9, 1, 0);
        nop(); step(); step(); step();
        ins(5'd9, 5'd0, 5'd0, 0, 0);
`ifdef RV_BP_WR_BACK_EN
        chk("dist4_bp1", bp1, 4'b0001);
`else
        chk("dist4_bp1", bp1, 4'b0000);
`endif

        // Load-use
        ins(5'd0, 5'd0, 5'd3, 1, 1);
        ins(5'd3, 5'd0, 5'd0, 0, 0);
        chk("lu_stall", o_st, 4'd1);
        chk("lu_falu1", o_fa, 4'd1);
        chk("lu_bubble_bp1", bp1, 4'd0);
        ins(5'd3, 5'd0, 5'd0, 0, 0);
        chk("lu_stall_once", o_st, 4'd0);
        chk("lu_mem_bp1", bp1, 4'b0100);

        // Youngest wins, x0, rs1==rs2
        ins(5'd0, 5'd0, 5'd4, 1, 0);
        ins(5'd0, 5'd0, 5'd4, 1, 0);
        ins(5'd4, 5'd0, 5'd0, 0, 0);
        chk("prio_bp1", bp1, 4'b1000);
        ins(5'd0, 5'd0, 5'd0, 1, 0);
        ins(5'd0, 5'd0, 5'd0, 0, 0);
        chk("x0_bp1", bp1, 4'd0);
        ins(5'd0, 5'd0, 5'd6, 1, 0);
        ins(5'd6, 5'd6, 5'd0, 0, 0);
        chk("same_bp1", bp1, 4'b1000);
        chk("same_bp2", bp2, 4'b1000);

        // Flush length, single and extended
        ins(5'd0, 5'd0, 5'd1, 1, 0);
        nop(); dv = 1; rs1 = 5'd1; req = 1; step();
        req = 0; cnt = 0;
        repeat (4) begin step(); cnt += int'(o_fd); end
        chk("flush_len", 4'(cnt), 4'(FC));
        nop(); req = 1; step();
        step();
        cnt = int'(o_fd);
        req = 0;
        repeat (5) begin step(); cnt += int'(o_fd); end
        chk("flush_ext_len", 4'(cnt), 4'(FC + 1));

        // External stall over a pending load-use
        ins(5'd0, 5'd0, 5'd8, 1, 1);
        held = bp1;
        nop(); dv = 1; rs1 = 5'd8; ext = 1;
        repeat (3) begin
            step();
            chk("ext_stall", o_st, 4'd1);
            chk("ext_falu1", o_fa, 4'd0);
            chk("ext_hold_bp1", bp1, held);
        end
        ext = 0; step();
        chk("ext_then_lu", o_st, 4'd1);
        step();
        chk("ext_lu_mem", bp1, 4'b0100);

        // Reset during flush
        nop(); req = 1; step();
        req = 0; step();
        chk("in_flush", o_fd, 4'd1);
        rst_n = 0; step();
        rst_n = 1; nop(); #1;
        chk("rst_fl_fdec", fd, 4'd0);
        chk("rst_fl_falu1", fa, 4'd0);
        chk("rst_fl_stall", stall, 4'd0);
        chk("rst_fl_bp1", bp1, 4'd0);

        // Random traffic
        repeat (800) begin
            rst_n = ($urandom_range(99) != 0);
            dv    = ($urandom_range(9) < 8);
            rs1   = 5'($urandom_range(7));
            rs2   = 5'($urandom_range(7));
            rd    = 5'($urandom_range(7));
            wr    = ($urandom_range(3) != 0);
            ld    = ($urandom_range(9) < 3);
            req   = ($urandom_range(24) == 0);
            ext   = ($urandom_range(9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
- Produces the per-operand bypass selects (ctrl_rs_bp_t) consumed by the first execute stage, plus the stall and flush controls for the front end.
- Keeps a destination-register scoreboard shadowing the alu1/alu2/memory/write/wr_back stages, with load-use stall and multi-cycle flush sequencing.
- Sits between decode and alu1, alongside the pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, number of cycles o_flush_dec/o_flush_alu1 stay asserted after a flush request (1..7).

Ports:
- i_clk  in  1  core clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_dec_valid  in  1  decode holds a valid instruction
- i_dec_rs1  in  5  source register 1 of decode instruction
- i_dec_rs2  in  5  source register 2 of decode instruction
- i_dec_rd  in  5  destination of decode instruction
- i_dec_reg_write  in  1  decode instruction writes rd
- i_dec_load  in  1  decode instruction result comes from memory (load)
- i_flush_req  in  1  branch mispredict / trap / mret redirect from alu2
- i_stall_ext  in  1  memory-side busy; freezes whole pipeline
- o_rs1_bp  out  ctrl_rs_bp_t  one-hot select {alu2, memory, write, wr_back} for rs1 of instruction in alu1; all-zero = register file
- o_rs2_bp  out  ctrl_rs_bp_t  same for rs2
- o_stall  out  1  hold fetch and decode registers
- o_flush_dec  out  1  clear decode stage register
- o_flush_alu1  out  1  clear alu1 stage register (bubble insert)

Behaviour:
- Scoreboard: 5 slots S_ALU1, S_ALU2, S_MEM, S_WR, S_WB; each holds {valid, rd, load}.
  - Slot valid only if reg_write=1 and rd!=0.
- Advance (no ext stall), per cycle:
  - S_WB<=S_WR, S_WR<=S_MEM, S_MEM<=S_ALU2, S_ALU2<=S_ALU1.
  - S_ALU1<=decode entry, or invalid when bubbling/flushing.
- Bypass compute, combinational against the stage each producer occupies next cycle:
  - match vs S_ALU1 -> alu2; S_ALU2 -> memory; S_MEM -> write; S_WR -> wr_back.
  - Youngest match wins (alu2 > memory > write > wr_back). rs==0 never matches.
  - Result registered into o_rsX_bp on advance, so it is aligned with the instruction while it sits in alu1. Latency exactly 1 cycle.
- Load-use: i_dec_valid and a decode rs matches S_ALU1 with load=1:
  - o_stall=1 and o_flush_alu1=1 for one cycle; S_ALU1 becomes invalid.
  - Next cycle the match falls on S_ALU2 (now holding the load), giving select=memory.
- States: RUN, LU_STALL, FLUSH.
  - RUN -> LU_STALL on load-use hazard.
  - LU_STALL -> RUN after 1 cycle.
  - any -> FLUSH on i_flush_req; counter loaded with FLUSH_CYCLES-1.
  - FLUSH: o_flush_dec=o_flush_alu1=1, S_ALU1 invalidated every cycle, o_rsX_bp forced 0. Counter decrements; returns to RUN when it reaches 0 with no new request.
  - i_flush_req while in FLUSH reloads the counter.
- Priority: reset > i_flush_req/FLUSH > i_stall_ext > load-use > advance.
- i_stall_ext=1: scoreboard, o_rsX_bp, state and flush counter hold. o_stall=1, o_flush_alu1=0, o_flush_dec=0, except while FLUSH is active, when both flushes stay asserted and the counter still decrements.
- Reset (i_reset_n=0 at clock edge): all slots invalid, state RUN, counter 0, o_rs1_bp=o_rs2_bp=0, o_stall=0, o_flush_dec=0, o_flush_alu1=0.
  - A reset during FLUSH or LU_STALL aborts it immediately.
- i_dec_valid=0: decode entry treated as invalid; no hazard raised.
- rs1==rs2 with a match: both selects identical.

Optional Feature:
- RV_BP_WR_BACK_EN
- Defined: S_WR matches produce the wr_back select.
- Undefined: wr_back field tied 0 and the S_WB slot is omitted. The register file must provide write-first read; S_WR matches fall through to the register file.

Test Plan:
- Back-to-back ALU: I0 rd=5 then I1 rs1=5, rs2=0 -> cycle I1 in alu1: o_rs1_bp.alu2=1, o_rs2_bp=0, no stall.
- Distance sweep: I0 rd=7, two unrelated fillers, I3 rs2=7 -> o_rs2_bp.write=1. With RV_BP_WR_BACK_EN, distance 4 gives wr_back=1; without it, 0.
- Load-use: load rd=3 followed by rs1=3 -> exactly one cycle o_stall=1, o_flush_alu1=1; next alu1 cycle o_rs1_bp.memory=1.
- Priority/x0: I0 rd=4, I1 rd=4, I2 rs1=4 -> alu2 select only. Any instruction rd=0 followed by rs1=0 -> select 0.
- Flush: i_flush_req pulse with FLUSH_CYCLES=2 -> o_flush_dec/o_flush_alu1 high exactly 2 cycles, bp outputs 0. Second pulse in cycle 2 extends to 3 total.
- Ext stall + reset: i_stall_ext held 3 cycles mid-hazard -> outputs frozen; reset asserted during FLUSH -> all outputs 0 next cycle, state RUN.
